// File: rtl/coremesh_cluster_clint.sv
// coremesh_cluster_clint
// Core-local interruptor for the cluster. A Wishbone target that provides
// per-core software-interrupt bits, a shared prescaled 64-bit machine timer
// and per-core 64-bit timer compares. It drives irq[i] = msip[i] | mtip[i].
//
// Ports:
//   clock, reset          - system clock, asynchronous active-high reset
//   t_adr, t_dat_w, t_sel - byte address (only [9:2] decoded), write data, byte selects
//   t_cyc, t_stb, t_we    - bus cycle, strobe, write enable
//   t_dat_r, t_ack, t_err - read data and termination, one cycle after acceptance
//   t_tga, t_tgc, t_tgd_w - address/cycle/write-data tags, ignored
//   t_tgd_r               - read data tag, always 0
//   irq                   - per-core interrupt lines (registered)
module coremesh_cluster_clint #(
  parameter int unsigned N_CORES   = 4,
  parameter int unsigned ADR_WIDTH = 32,
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned TGA_WIDTH = 1,
  parameter int unsigned TGD_WIDTH = 1,
  parameter int unsigned TGC_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] t_adr,
  input  logic [DAT_WIDTH-1:0] t_dat_w,
  output logic [DAT_WIDTH-1:0] t_dat_r,
  input  logic                 t_cyc,
  input  logic                 t_stb,
  input  logic                 t_we,
  input  logic [3:0]           t_sel,
  output logic                 t_ack,
  output logic                 t_err,
  input  logic [TGA_WIDTH-1:0] t_tga,
  input  logic [TGC_WIDTH-1:0] t_tgc,
  input  logic [TGD_WIDTH-1:0] t_tgd_w,
  output logic [TGD_WIDTH-1:0] t_tgd_r,
  output logic [N_CORES-1:0]   irq
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e             state_q;
  logic [N_CORES-1:0] msip_q;
  logic [N_CORES-1:0] mtip_q;
  logic [63:0]        mtime_q, mtime_d;
  logic [31:0]        shadow_q;
  logic [63:0]        mtimecmp_q [N_CORES];
  logic [15:0]        prescale_q;
  logic [15:0]        pcnt_q, pcnt_d;
  logic               tick;

  // Decode results
  logic [7:0]         word;
  logic               hit;
  logic [31:0]        rdata;
  logic [N_CORES-1:0] hit_msip, hit_cmp_lo, hit_cmp_hi;
  logic               hit_mtime_lo, hit_mtime_hi, hit_prescale;
  logic               accept, wr_en, rd_en;

  logic unused_inputs;
  assign unused_inputs = ^{t_adr[ADR_WIDTH-1:10], t_adr[1:0], t_tga, t_tgc, t_tgd_w};

  assign t_tgd_r = '0;
  assign word    = t_adr[9:2];
  assign accept  = (state_q == StIdle) && t_cyc && t_stb;
  assign wr_en   = accept && t_we && hit;
  assign rd_en   = accept && !t_we && hit;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode and read mux, from register state before the accepting edge.
  always_comb begin
    hit          = 1'b0;
    rdata        = '0;
    hit_msip     = '0;
    hit_cmp_lo   = '0;
    hit_cmp_hi   = '0;
    hit_mtime_lo = 1'b0;
    hit_mtime_hi = 1'b0;
    hit_prescale = 1'b0;
    case (word[7:6])
      2'b00: begin
        for (int i = 0; i < N_CORES; i++) begin
          if (word[5:0] == 6'(i)) begin
            hit         = 1'b1;
            hit_msip[i] = 1'b1;
            rdata       = {31'b0, msip_q[i]};
          end
        end
      end
      2'b01: begin
        if (word[5:1] == 5'd0) begin
          hit = 1'b1;
          if (word[0]) begin
            hit_mtime_hi = 1'b1;
            rdata        = shadow_q;
          end else begin
            hit_mtime_lo = 1'b1;
            rdata        = mtime_q[31:0];
          end
        end
      end
      2'b10: begin
        for (int i = 0; i < N_CORES; i++) begin
          if (word[5:1] == 5'(i)) begin
            hit = 1'b1;
            if (word[0]) begin
              hit_cmp_hi[i] = 1'b1;
              rdata         = mtimecmp_q[i][63:32];
            end else begin
              hit_cmp_lo[i] = 1'b1;
              rdata         = mtimecmp_q[i][31:0];
            end
          end
        end
      end
      default: begin
        if (word[5:0] == 6'd0) begin
          hit          = 1'b1;
          hit_prescale = 1'b1;
          rdata        = {16'b0, prescale_q};
        end
      end
    endcase
  end

  // Timer next state. A bus write to one MTIME half wins over a tick; the
  // other half keeps its pre-tick value and the tick is dropped.
  always_comb begin
    tick    = (pcnt_q == prescale_q);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_en && hit_mtime_lo) begin
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], t_dat_w, t_sel)};
    end else if (wr_en && hit_mtime_hi) begin
      mtime_d = {merge_bytes(mtime_q[63:32], t_dat_w, t_sel), mtime_q[31:0]};
    end
    pcnt_d = (tick || (wr_en && hit_prescale)) ? 16'd0 : pcnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      t_ack      <= 1'b0;
      t_err      <= 1'b0;
      t_dat_r    <= '0;
      irq        <= '0;
      msip_q     <= '0;
      mtip_q     <= '0;
      mtime_q    <= '0;
      shadow_q   <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      for (int i = 0; i < N_CORES; i++) mtimecmp_q[i] <= '1;
    end else begin
      mtime_q <= mtime_d;
      pcnt_q  <= pcnt_d;
      irq     <= msip_q | mtip_q;

      for (int i = 0; i < N_CORES; i++) begin
        mtip_q[i] <= (mtime_q >= mtimecmp_q[i]);
        if (wr_en && hit_msip[i] && t_sel[0]) msip_q[i] <= t_dat_w[0];
        if (wr_en && hit_cmp_lo[i]) begin
          mtimecmp_q[i][31:0] <= merge_bytes(mtimecmp_q[i][31:0], t_dat_w, t_sel);
        end
        if (wr_en && hit_cmp_hi[i]) begin
          mtimecmp_q[i][63:32] <= merge_bytes(mtimecmp_q[i][63:32], t_dat_w, t_sel);
        end
      end

      if (wr_en && hit_prescale) begin
        prescale_q <= {t_sel[1] ? t_dat_w[15:8] : prescale_q[15:8],
                       t_sel[0] ? t_dat_w[7:0]  : prescale_q[7:0]};
      end

      // Latch the upper half when the lower half is read so a LO/HI pair is coherent.
      if (rd_en && hit_mtime_lo) shadow_q <= mtime_q[63:32];

      case (state_q)
        StIdle: begin
          if (t_cyc && t_stb) begin
            state_q <= StResp;
            t_ack   <= hit;
            t_err   <= !hit;
            t_dat_r <= (hit && !t_we) ? rdata : '0;
          end
        end
        StResp: begin
          state_q <= StIdle;
          t_ack   <= 1'b0;
          t_err   <= 1'b0;
          t_dat_r <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_coremesh_cluster_clint.sv
// Testbench for coremesh_cluster_clint: directed and randomized bus traffic,
// a timer reference model computed from tick schedules, and a response
// scoreboard checked by an independent monitor.
module tb_coremesh_cluster_clint;

  localparam int unsigned NC = 4;

  typedef logic [63:0] u64_t;
  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
    int          edge_at;
    int          off;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] t_adr, t_dat_w, t_dat_r;
  logic        t_cyc, t_stb, t_we;
  logic [3:0]  t_sel;
  logic        t_ack, t_err;
  logic [0:0]  t_tga, t_tgd_w, t_tgd_r;
  logic [3:0]  t_tgc;
  logic [NC-1:0] irq;

  coremesh_cluster_clint #(.N_CORES(NC)) dut (
    .clock   (clock),
    .reset   (reset),
    .t_adr   (t_adr),
    .t_dat_w (t_dat_w),
    .t_dat_r (t_dat_r),
    .t_cyc   (t_cyc),
    .t_stb   (t_stb),
    .t_we    (t_we),
    .t_sel   (t_sel),
    .t_ack   (t_ack),
    .t_err   (t_err),
    .t_tga   (t_tga),
    .t_tgc   (t_tgc),
    .t_tgd_w (t_tgd_w),
    .t_tgd_r (t_tgd_r),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  resp_t sb[$];

  // Reference model: MTIME after edge e is m_base plus the ticks of the
  // schedule (edges m_cw + k*(m_p+1)) that fall in (m_cbase, e].
  u64_t        m_base;
  int          m_cbase, m_cw, m_p;
  logic [NC-1:0] msip_m;
  logic [63:0] cmp_m [NC];
  logic [15:0] presc_m;
  logic [31:0] shadow_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic u64_t mtime_at(input int e);
    int n;
    n = (e - m_cw) / (m_p + 1) - (m_cbase - m_cw) / (m_p + 1);
    return m_base + 64'(n);
  endfunction

  function automatic logic [31:0] bytes_merge(input logic [31:0] old_v, input logic [31:0] wd,
                                              input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [NC-1:0] exp_irq(input int e);
    logic [NC-1:0] r;
    u64_t mt;
    mt = mtime_at(e - 2);
    for (int i = 0; i < NC; i++) r[i] = msip_m[i] | (mt >= cmp_m[i]);
    return r;
  endfunction

  task automatic model_reset(input int e);
    m_base   = '0;
    m_cbase  = e;
    m_cw     = e;
    m_p      = 0;
    msip_m   = '0;
    presc_m  = '0;
    shadow_m = '0;
    for (int i = 0; i < NC; i++) cmp_m[i] = '1;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      edge_n++;
    end
  end

  // Monitor: every response pulse pops one expectation.
  initial begin
    resp_t r;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1 && (t_ack === 1'b1 || t_err === 1'b1)) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'({t_ack, t_err}), 64'd0);
        end else begin
          r = sb.pop_front();
          chk($sformatf("resp_kind@%0h", r.off), 64'({t_ack, t_err}), 64'({!r.err, r.err}));
          chk($sformatf("resp_edge@%0h", r.off), 64'(edge_n), 64'(r.edge_at));
          if (r.chk_data) chk($sformatf("rdata@%0h", r.off), 64'(t_dat_r), 64'(r.data));
          chk("tgd_r", 64'(t_tgd_r), 64'd0);
        end
      end
    end
  end

  // One bus access; called at #1 after a clock edge with the DUT idle.
  task automatic bus(input logic we, input logic [9:0] off, input logic [31:0] wd,
                     input logic [3:0] sel);
    resp_t       r;
    int          acc, o, i;
    logic        hit;
    logic [31:0] rd, tmp;
    u64_t        pre;
    acc = edge_n + 1;
    o   = int'(off) & 'h3FC;
    hit = 1'b0;
    rd  = '0;
    if (o < 'h100) begin
      i = o / 4;
      if (i < NC) begin
        hit = 1'b1;
        rd  = {31'b0, msip_m[i]};
        if (we && sel[0]) msip_m[i] = wd[0];
      end
    end else if (o == 'h100 || o == 'h104) begin
      hit = 1'b1;
      pre = mtime_at(acc - 1);
      rd  = (o == 'h100) ? pre[31:0] : shadow_m;
      if (we) begin
        if (o == 'h100) pre[31:0] = bytes_merge(pre[31:0], wd, sel);
        else pre[63:32] = bytes_merge(pre[63:32], wd, sel);
        m_base  = pre;
        m_cbase = acc;
      end else if (o == 'h100) begin
        shadow_m = pre[63:32];
      end
    end else if (o >= 'h200 && o < 'h300) begin
      i = (o - 'h200) / 8;
      if (i < NC) begin
        hit = 1'b1;
        if ((o % 8) == 4) begin
          rd = cmp_m[i][63:32];
          if (we) cmp_m[i][63:32] = bytes_merge(cmp_m[i][63:32], wd, sel);
        end else begin
          rd = cmp_m[i][31:0];
          if (we) cmp_m[i][31:0] = bytes_merge(cmp_m[i][31:0], wd, sel);
        end
      end
    end else if (o == 'h300) begin
      hit = 1'b1;
      rd  = {16'b0, presc_m};
      if (we) begin
        tmp     = bytes_merge({16'b0, presc_m}, wd, sel);
        m_base  = mtime_at(acc);
        m_cbase = acc;
        m_cw    = acc;
        m_p     = int'(tmp[15:0]);
        presc_m = tmp[15:0];
      end
    end
    r.err      = !hit;
    r.chk_data = !we || !hit;
    r.data     = (hit && !we) ? rd : 32'd0;
    r.edge_at  = acc;
    r.off      = o;
    sb.push_back(r);

    t_adr   = {22'($urandom), off};
    t_we    = we;
    t_dat_w = wd;
    t_sel   = sel;
    t_tga   = 1'($urandom);
    t_tgc   = 4'($urandom);
    t_tgd_w = 1'($urandom);
    t_cyc   = 1'b1;
    t_stb   = 1'b1;
    @(posedge clock);
    #1;
    t_cyc = 1'b0;
    t_stb = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic check_irq(input string name);
    @(posedge clock);
    #1;
    chk(name, 64'(irq), 64'(exp_irq(edge_n)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_ack", 64'(t_ack), 64'd0);
    chk("reset_err", 64'(t_err), 64'd0);
    chk("reset_dat", 64'(t_dat_r), 64'd0);
    chk("reset_irq", 64'(irq), 64'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset(edge_n);
  endtask

  initial begin
    logic [9:0]  off;
    logic [31:0] wd;
    t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0; t_sel = '0;
    t_adr = '0; t_dat_w = '0; t_tga = '0; t_tgc = '0; t_tgd_w = '0;
    @(posedge clock);
    #1;
    do_reset();

    // Compare reset value, then MSIP set/clear.
    bus(1'b0, 10'h210, 32'h0, 4'h0);
    check_irq("irq_after_reset");
    bus(1'b1, 10'h004, 32'h1, 4'b0001);
    check_irq("irq_msip1_set");
    bus(1'b0, 10'h004, 32'h0, 4'h0);
    bus(1'b1, 10'h004, 32'h0, 4'b0001);
    check_irq("irq_msip1_clear");

    // Prescaled counting, then full rate.
    bus(1'b1, 10'h300, 32'd3, 4'b0011);
    bus(1'b1, 10'h100, 32'd0, 4'hF);
    bus(1'b1, 10'h104, 32'd0, 4'hF);
    repeat (40) @(posedge clock);
    #1;
    bus(1'b0, 10'h100, 32'h0, 4'h0);
    bus(1'b0, 10'h300, 32'h0, 4'h0);
    bus(1'b1, 10'h300, 32'd0, 4'b0011);
    bus(1'b0, 10'h100, 32'h0, 4'h0);
    bus(1'b0, 10'h100, 32'h0, 4'h0);

    // Carry from LO into HI and shadowed HI read.
    bus(1'b1, 10'h100, 32'hFFFF_FFFE, 4'hF);
    bus(1'b1, 10'h104, 32'h0, 4'hF);
    bus(1'b0, 10'h100, 32'h0, 4'h0);
    bus(1'b0, 10'h104, 32'h0, 4'h0);

    // Timer compare on core 0: watch irq rise cycle by cycle, then fall.
    bus(1'b1, 10'h200, 32'd100, 4'hF);
    bus(1'b1, 10'h204, 32'd0, 4'hF);
    bus(1'b1, 10'h100, 32'd0, 4'hF);
    bus(1'b1, 10'h104, 32'd0, 4'hF);
    for (int k = 0; k < 110; k++) check_irq("irq_mtimecmp_rise");
    bus(1'b1, 10'h204, 32'd1, 4'hF);
    check_irq("irq_mtimecmp_fall");

    // Unmapped accesses.
    bus(1'b1, 10'h380, 32'hFFFF_FFFF, 4'hF);
    bus(1'b0, 10'h380, 32'h0, 4'h0);
    bus(1'b1, 10'h014, 32'h1, 4'hF);
    check_irq("irq_after_unmapped");
    bus(1'b0, 10'h014, 32'h0, 4'h0);
    bus(1'b0, 10'h228, 32'h0, 4'h0);
    bus(1'b0, 10'h300, 32'h0, 4'h0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 6))
        0:       off = 10'(4 * $urandom_range(0, NC + 1));
        1:       off = 10'h100;
        2:       off = 10'h104;
        3, 4:    off = 10'('h200 + 8 * $urandom_range(0, NC) + 4 * $urandom_range(0, 1));
        5:       off = 10'h300;
        default: off = 10'(4 * $urandom_range(0, 255));
      endcase
      wd = $urandom;
      if ((off & 10'h3FC) == 10'h300) wd = 32'($urandom_range(0, 4));
      bus(1'($urandom), off, wd, 4'($urandom));
      check_irq("irq_random");
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    // Reset while a response is being presented.
    bus(1'b1, 10'h008, 32'h1, 4'h1);
    bus(1'b1, 10'h300, 32'd2, 4'h1);
    sb.push_back('{err: 1'b0, chk_data: 1'b1, data: 32'h0, edge_at: edge_n + 1, off: 'h20C});
    t_adr = 32'h20C; t_we = 1'b0; t_sel = 4'h0; t_cyc = 1'b1; t_stb = 1'b1;
    @(posedge clock);
    #1;
    t_cyc = 1'b0;
    t_stb = 1'b0;
    do_reset();
    bus(1'b0, 10'h008, 32'h0, 4'h0);
    bus(1'b0, 10'h300, 32'h0, 4'h0);
    bus(1'b0, 10'h20C, 32'h0, 4'h0);
    bus(1'b0, 10'h104, 32'h0, 4'h0);
    bus(1'b0, 10'h100, 32'h0, 4'h0);
    check_irq("irq_after_mid_reset");

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
